// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, control-field codes, NOP bundle and FSM states shared by the decode stage
package decode_pkg;
    localparam logic [3:0] OP_ADI  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_NAND = 4'b0010;
    localparam logic [3:0] OP_LHI  = 4'b0011;
    localparam logic [3:0] OP_LW   = 4'b0100;
    localparam logic [3:0] OP_SW   = 4'b0101;
    localparam logic [3:0] OP_LM   = 4'b0110;
    localparam logic [3:0] OP_SM   = 4'b0111;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_JAL  = 4'b1001;
    localparam logic [3:0] OP_JLR  = 4'b1010;
    localparam logic [3:0] OP_JRI  = 4'b1011;
    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_LOAD  = 2'b01;
    localparam logic [1:0] MEM_STORE = 2'b10;
    localparam logic [2:0] WB_NONE = 3'b000;
    localparam logic [2:0] WB_MEM  = 3'b100;
    localparam logic [2:0] WB_PC   = 3'b101;
    localparam logic [2:0] WB_ALU  = 3'b110;
    localparam logic [2:0] WB_IMM  = 3'b111;
    localparam logic [3:0] EX_ADD  = 4'b0000;
    localparam logic [3:0] EX_LHI  = 4'b1001;
    localparam logic [3:0] EX_NOP  = 4'b1111;
    typedef struct packed {
        logic [1:0] mem;
        logic [2:0] wb;
        logic [3:0] ex;
    } ctl_t;
    localparam ctl_t NOP_CTL = '{mem: MEM_NONE, wb: WB_NONE, ex: EX_NOP};
    typedef enum logic {IDLE, EXPAND} state_t;
endpackage

// File: rtl/decode_comb.sv
// decode_comb: combinational field decode of one instruction for a given LM/SM register (DECODE_ILLEGAL_FLAG_EN adds illegal)
module decode_comb import decode_pkg::*; #(
    parameter int REG_AW = 3,
    parameter bit ILLEGAL_AS_NOP = 1'b1
) (
    input  logic [15:0]       instr,
    input  logic [REG_AW-1:0] cur_reg,
    output ctl_t              ctl,
    output logic [REG_AW-1:0] src1,
    output logic [REG_AW-1:0] src2,
    output logic [REG_AW-1:0] dest,
    output logic              imm_control
`ifdef DECODE_ILLEGAL_FLAG_EN
    ,
    output logic              illegal
`endif
);
    localparam int MW = 2**REG_AW;
    logic [3:0] op;
    logic       ill;
    ctl_t       raw;
    assign op = instr[15:12];
`ifdef DECODE_ILLEGAL_FLAG_EN
    assign illegal = ill;
`endif
    // opcode table; zero-mask LM/SM and (optionally) illegal encodings collapse to NOP control
    always_comb begin
        raw = '{mem: MEM_NONE, wb: WB_NONE, ex: EX_ADD};
        src1 = instr[11:9];
        src2 = instr[8:6];
        dest = '0;
        imm_control = 1'b0;
        ill = 1'b0;
        case (op)
            OP_ADI: begin raw.wb = WB_ALU; raw.ex = EX_NOP; imm_control = 1'b1; dest = instr[8:6]; end
            OP_ADD: begin raw.wb = WB_ALU; raw.ex = {2'b00, instr[1:0]}; dest = instr[5:3]; end
            OP_NAND: begin
                raw.wb = WB_ALU;
                dest = instr[5:3];
                raw.ex = instr[1:0] == 2'b00 ? 4'b0100 : instr[1:0] == 2'b10 ? 4'b0101 :
                         instr[1:0] == 2'b01 ? 4'b0110 : EX_ADD;
                ill = instr[1:0] == 2'b11;
            end
            OP_LHI: begin raw.wb = WB_IMM; raw.ex = EX_LHI; dest = instr[11:9]; end
            OP_LW: begin raw = '{mem: MEM_LOAD, wb: WB_MEM, ex: EX_NOP}; dest = instr[8:6]; end
            OP_SW: raw = '{mem: MEM_STORE, wb: WB_NONE, ex: EX_NOP};
            OP_LM: begin raw = '{mem: MEM_LOAD, wb: WB_MEM, ex: EX_NOP}; dest = cur_reg; end
            OP_SM: begin raw = '{mem: MEM_STORE, wb: WB_NONE, ex: EX_NOP}; src2 = cur_reg; end
            OP_BEQ: imm_control = 1'b1;
            OP_JAL, OP_JLR: begin raw.wb = WB_PC; dest = instr[11:9]; end
            OP_JRI: ;
            default: ill = 1'b1;
        endcase
        ctl = ((op == OP_LM || op == OP_SM) && ~|instr[MW-1:0]) || (ill && ILLEGAL_AS_NOP) ? NOP_CTL : raw;
    end
endmodule

// File: rtl/decode_stage_seq.sv
// decode_stage_seq: registered valid/ready decode stage with LM/SM expansion and flush (DECODE_ILLEGAL_FLAG_EN adds illegal)
module decode_stage_seq import decode_pkg::*; #(
    parameter int PC_W = 16,
    parameter int REG_AW = 3,
    parameter bit ILLEGAL_AS_NOP = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [1:0]        Mem,
    output logic [2:0]        WB,
    output logic [3:0]        Ex,
    output logic [REG_AW-1:0] src1,
    output logic [REG_AW-1:0] src2,
    output logic [REG_AW-1:0] dest,
    output logic [5:0]        Imm_6,
    output logic [8:0]        Imm_9,
    output logic              imm_control,
    output logic [REG_AW-1:0] uop_offset,
    output logic              uop_last
`ifdef DECODE_ILLEGAL_FLAG_EN
    ,
    output logic              illegal
`endif
);
    localparam int MW = 2**REG_AW;
    state_t            state;
    logic [15:0]       lat_instr;
    logic [PC_W-1:0]   lat_pc;
    logic [MW-1:0]     rem_mask;
    logic [15:0]       sel_instr;
    logic [PC_W-1:0]   sel_pc;
    logic [MW-1:0]     sel_mask;
    logic [MW-1:0]     rest;
    logic [REG_AW-1:0] cur_reg;
    logic              multi;
    logic              load;
    ctl_t              ctl;
    logic [REG_AW-1:0] d_src1, d_src2, d_dest;
    logic              d_immc;
`ifdef DECODE_ILLEGAL_FLAG_EN
    logic              d_ill;
`endif

    function automatic logic [REG_AW-1:0] lowest(input logic [MW-1:0] m);
        lowest = '0;
        for (int i = MW-1; i >= 0; i--) if (m[i]) lowest = REG_AW'(i);
    endfunction

    assign in_ready  = state == IDLE && (!out_valid || out_ready) && !flush;
    assign sel_instr = state == EXPAND ? lat_instr : in_instr;
    assign sel_pc    = state == EXPAND ? lat_pc : in_pc;
    assign sel_mask  = state == EXPAND ? rem_mask : in_instr[MW-1:0];
    assign rest      = sel_mask & (sel_mask - MW'(1));
    assign cur_reg   = lowest(sel_mask);
    assign multi     = sel_instr[15:12] == OP_LM || sel_instr[15:12] == OP_SM;
    assign load      = (in_valid && in_ready) || (state == EXPAND && out_ready && !flush);

    decode_comb #(.REG_AW(REG_AW), .ILLEGAL_AS_NOP(ILLEGAL_AS_NOP)) u_comb (
        .instr(sel_instr),
        .cur_reg(cur_reg),
        .ctl(ctl),
        .src1(d_src1),
        .src2(d_src2),
        .dest(d_dest),
        .imm_control(d_immc)
`ifdef DECODE_ILLEGAL_FLAG_EN
        ,
        .illegal(d_ill)
`endif
    );

    // output register and expansion FSM: load a micro-op on accept/advance, drain when taken, flush kills all
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            out_valid <= 1'b0;
            lat_instr <= '0;
            lat_pc <= '0;
            rem_mask <= '0;
            out_pc <= '0;
            Mem <= MEM_NONE;
            WB <= WB_NONE;
            Ex <= EX_NOP;
            src1 <= '0;
            src2 <= '0;
            dest <= '0;
            Imm_6 <= '0;
            Imm_9 <= '0;
            imm_control <= 1'b0;
            uop_offset <= '0;
            uop_last <= 1'b1;
`ifdef DECODE_ILLEGAL_FLAG_EN
            illegal <= 1'b0;
`endif
        end else if (flush) begin
            state <= IDLE;
            out_valid <= 1'b0;
            rem_mask <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            lat_instr <= sel_instr;
            lat_pc <= sel_pc;
            rem_mask <= multi ? rest : '0;
            state <= multi && |rest ? EXPAND : IDLE;
            out_pc <= sel_pc;
            Mem <= ctl.mem;
            WB <= ctl.wb;
            Ex <= ctl.ex;
            src1 <= d_src1;
            src2 <= d_src2;
            dest <= d_dest;
            Imm_6 <= sel_instr[5:0];
            Imm_9 <= sel_instr[8:0];
            imm_control <= d_immc;
            uop_offset <= state == EXPAND ? uop_offset + REG_AW'(1) : '0;
            uop_last <= !multi || ~|rest;
`ifdef DECODE_ILLEGAL_FLAG_EN
            illegal <= d_ill;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_decode_stage_seq.sv
// tb_decode_stage_seq: directed plus random stimulus checked against a queue-based micro-op model
module tb_decode_stage_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_instr = '0;
    logic [15:0] in_pc = '0;
    logic        in_ready, out_valid, imm_control, uop_last;
    logic [15:0] out_pc;
    logic [1:0]  Mem;
    logic [2:0]  WB, src1, src2, dest, uop_offset;
    logic [3:0]  Ex;
    logic [5:0]  Imm_6;
    logic [8:0]  Imm_9;
`ifdef DECODE_ILLEGAL_FLAG_EN
    logic        illegal;
`endif

    decode_stage_seq dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .Mem(Mem), .WB(WB), .Ex(Ex), .src1(src1), .src2(src2), .dest(dest),
        .Imm_6(Imm_6), .Imm_9(Imm_9), .imm_control(imm_control),
        .uop_offset(uop_offset), .uop_last(uop_last)
`ifdef DECODE_ILLEGAL_FLAG_EN
        , .illegal(illegal)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mem;
        logic [2:0]  wb;
        logic [3:0]  ex;
        logic [2:0]  s1, s2, d, off;
        logic [5:0]  i6;
        logic [8:0]  i9;
        logic        ic, last, ill;
        logic [15:0] pc;
    } uop_t;

    uop_t pend[$];
    uop_t exq[$];
    uop_t cur;
    bit   mv = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic uop_t dec(input logic [15:0] i, input logic [2:0] r, input logic [15:0] pc,
                                 input int off, input bit last);
        uop_t u;
        u.mem = 0; u.wb = 0; u.ex = 0; u.ic = 0; u.ill = 0; u.d = 0;
        u.s1 = i[11:9]; u.s2 = i[8:6]; u.i6 = i[5:0]; u.i9 = i[8:0];
        u.pc = pc; u.off = 3'(off); u.last = last;
        case (i[15:12])
            0: begin u.wb = 6; u.ex = 15; u.ic = 1; u.d = i[8:6]; end
            1: begin u.wb = 6; u.d = i[5:3]; u.ex = 4'(i[1:0]); end
            2: begin
                u.wb = 6; u.d = i[5:3];
                if (i[1:0] == 0) u.ex = 4; else if (i[1:0] == 2) u.ex = 5; else if (i[1:0] == 1) u.ex = 6;
                else u.ill = 1;
            end
            3: begin u.wb = 7; u.ex = 9; u.d = i[11:9]; end
            4: begin u.mem = 1; u.wb = 4; u.ex = 15; u.d = i[8:6]; end
            5: begin u.mem = 2; u.ex = 15; end
            6: begin u.mem = 1; u.wb = 4; u.ex = 15; u.d = r; end
            7: begin u.mem = 2; u.ex = 15; u.s2 = r; end
            8: u.ic = 1;
            9, 10: begin u.wb = 5; u.d = i[11:9]; end
            11: ;
            default: u.ill = 1;
        endcase
        if (u.ill) begin u.mem = 0; u.wb = 0; u.ex = 15; end
        return u;
    endfunction

    // builds the full list of micro-ops one instruction produces
    task automatic expand(input logic [15:0] i, input logic [15:0] pc);
        int n = 0;
        int total = $countones(i[7:0]);
        uop_t u;
        exq.delete();
        if (i[15:13] == 3'b011) begin
            for (int r = 0; r < 8; r++)
                if (i[r]) begin
                    exq.push_back(dec(i, 3'(r), pc, n, n == total - 1));
                    n++;
                end
            if (total == 0) begin
                u = dec(i, 0, pc, 0, 1);
                u.mem = 0; u.wb = 0; u.ex = 15;
                exq.push_back(u);
            end
        end else exq.push_back(dec(i, 0, pc, 0, 1));
    endtask

    task automatic check_out();
        cmp("out_valid", out_valid, mv);
        if (mv) begin
            cmp("Mem", Mem, cur.mem);
            cmp("WB", WB, cur.wb);
            cmp("Ex", Ex, cur.ex);
            cmp("src1", src1, cur.s1);
            cmp("src2", src2, cur.s2);
            cmp("dest", dest, cur.d);
            cmp("Imm_6", Imm_6, cur.i6);
            cmp("Imm_9", Imm_9, cur.i9);
            cmp("imm_control", imm_control, cur.ic);
            cmp("uop_offset", uop_offset, cur.off);
            cmp("uop_last", uop_last, cur.last);
            cmp("out_pc", out_pc, cur.pc);
`ifdef DECODE_ILLEGAL_FLAG_EN
            cmp("illegal", illegal, cur.ill);
`endif
        end
    endtask

    // one clock: check in_ready before the edge, advance the model, check outputs after it
    task automatic cycle();
        bit rdy;
        #1;
        rdy = pend.size() == 0 && (!mv || out_ready) && !flush;
        cmp("in_ready", in_ready, rdy);
        @(posedge clk);
        #1;
        if (flush) begin
            mv = 0;
            pend.delete();
        end else if (mv && out_ready && pend.size() > 0) cur = pend.pop_front();
        else if (in_valid && rdy) begin
            expand(in_instr, in_pc);
            cur = exq.pop_front();
            pend = exq;
            mv = 1;
        end else if (out_ready) mv = 0;
        check_out();
    endtask

    initial begin
        #12;
        cmp("rst_out_valid", out_valid, 0);
        cmp("rst_Ex", Ex, 4'b1111);
        cmp("rst_uop_last", uop_last, 1);
        cmp("rst_Mem", Mem, 0);
        cmp("rst_WB", WB, 0);
        cmp("rst_dest", dest, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        // ADD R3,R1,R2
        in_instr = 16'h1298; in_pc = 16'h0100; in_valid = 1; out_ready = 1;
        cycle();
        in_valid = 0;
        cmp("add_Ex", Ex, 4'b0000);
        cmp("add_WB", WB, 3'b110);
        cmp("add_dest", dest, 3);
        cycle();
        // LM base R2 mask 0x25
        in_instr = 16'h6425; in_pc = 16'h0102; in_valid = 1;
        cycle();
        in_valid = 0;
        cmp("lm_dest0", dest, 0);
        cycle();
        cmp("lm_dest1", dest, 2);
        cycle();
        cmp("lm_dest2", dest, 5);
        cmp("lm_last", uop_last, 1);
        cycle();
        // ADI stalled by downstream for 4 cycles with another instruction waiting
        in_instr = 16'h0A45; in_pc = 16'h0104; in_valid = 1; out_ready = 0;
        cycle();
        in_instr = 16'h1298; in_pc = 16'h0106;
        repeat (4) cycle();
        out_ready = 1;
        cycle();
        in_valid = 0;
        cycle();
        cycle();
        // SM flushed after its second micro-op
        in_instr = 16'h740F; in_pc = 16'h0108; in_valid = 1;
        cycle();
        in_valid = 0;
        cycle();
        flush = 1;
        cycle();
        flush = 0;
        in_instr = 16'h2A50; in_pc = 16'h010A; in_valid = 1;
        cycle();
        in_valid = 0;
        cycle();
        // LM with empty mask
        in_instr = 16'h6400; in_pc = 16'h010C; in_valid = 1;
        cycle();
        in_valid = 0;
        cmp("lm0_Ex", Ex, 4'b1111);
        cmp("lm0_last", uop_last, 1);
        cycle();
        // undefined opcode
        in_instr = 16'hE123; in_pc = 16'h010E; in_valid = 1;
        cycle();
        in_valid = 0;
        cmp("ill_WB", WB, 0);
        cycle();
        // randomized traffic
        repeat (600) begin
            in_valid = 1'($urandom_range(0, 1));
            in_instr = 16'($urandom);
            if ($urandom_range(0, 2) == 0) in_instr[15:13] = 3'b011;
            in_pc = 16'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 24) == 0;
            cycle();
        end
        flush = 0;
        // asynchronous reset in the middle of an expansion
        in_instr = 16'h6CFF; in_pc = 16'h0200; in_valid = 1; out_ready = 1;
        cycle();
        in_valid = 0;
        cycle();
        #2 rst_n = 1'b0;
        #1;
        cmp("async_rst_valid", out_valid, 0);
        cmp("async_rst_ready", in_ready, 1);
        mv = 0;
        pend.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_instr = 16'h1298; in_pc = 16'h0300; in_valid = 1;
        cycle();
        in_valid = 0;
        cycle();
        cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
